// File: rtl/prl_hard_reset_rx_if.sv
// Bundle of PHY, TCPC register and policy-engine signals around the Hard Reset receiver.
// master drives the receiver's inputs; slave is the receiver itself.
interface prl_hard_reset_rx_if;
  logic        PHY_rx_hard_reset;
  logic        PHY_rx_cable_reset;
  logic [7:0]  RECEIVE_DETECT;
  logic [15:0] ALERT_clear;
  logic        PE_hard_reset_done;
  logic [15:0] ALERT;
  logic        RECEIVE_DETECT_clear;
  logic [7:0]  RECEIVE_BYTE_COUNT;
  logic        prl_layer_reset;
  logic        rx_buffer_flush;
  logic        PE_hard_reset_ind;
  logic        rx_is_cable;
  logic        hr_busy;
  logic        hr_done;
  logic        hr_timeout;
`ifdef HR_RX_EVENT_COUNT_EN
  logic [7:0]  hr_event_count;
`endif

  modport master (
    output PHY_rx_hard_reset, PHY_rx_cable_reset, RECEIVE_DETECT, ALERT_clear, PE_hard_reset_done,
    input  ALERT, RECEIVE_DETECT_clear, RECEIVE_BYTE_COUNT, prl_layer_reset, rx_buffer_flush,
           PE_hard_reset_ind, rx_is_cable, hr_busy, hr_done, hr_timeout
`ifdef HR_RX_EVENT_COUNT_EN
    , input hr_event_count
`endif
  );

  modport slave (
    input  PHY_rx_hard_reset, PHY_rx_cable_reset, RECEIVE_DETECT, ALERT_clear, PE_hard_reset_done,
    output ALERT, RECEIVE_DETECT_clear, RECEIVE_BYTE_COUNT, prl_layer_reset, rx_buffer_flush,
           PE_hard_reset_ind, rx_is_cable, hr_busy, hr_done, hr_timeout
`ifdef HR_RX_EVENT_COUNT_EN
    , output hr_event_count
`endif
  );
endinterface

// File: rtl/prl_hard_reset_rx.sv
// Receive-side Hard/Cable Reset handler: resets PRL, flushes RX, raises ALERT, handshakes with PE (HR_RX_EVENT_COUNT_EN adds hr_event_count).
// Latency: accepted pulse at edge k -> prl_layer_reset in k+1, PE_hard_reset_ind and ALERT[3] in k+2.
// No backpressure: pulses arriving while busy are dropped; PE done or timeout ends the sequence.
module prl_hard_reset_rx #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMER_W        = 10
) (
  input logic                CLK,
  input logic                reset,
  prl_hard_reset_rx_if.slave bus
);

  typedef enum logic [4:0] {
    IDLE        = 5'b00001,
    RESET_LAYER = 5'b00010,
    INDICATE    = 5'b00100,
    WAIT_PE     = 5'b01000,
    COMPLETE    = 5'b10000
  } state_t;

  localparam logic [TIMER_W-1:0] TMR_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic               alert_hr, alert_hr_nxt;
  logic               is_cable, is_cable_nxt;
  logic               timeout, timeout_nxt;
  logic [7:0]         byte_count, byte_count_nxt;
  logic               accept_hr, accept_cr, accept;

  assign accept_hr = bus.PHY_rx_hard_reset  & bus.RECEIVE_DETECT[5];
  assign accept_cr = bus.PHY_rx_cable_reset & bus.RECEIVE_DETECT[6];
  assign accept    = (state == IDLE) & (accept_hr | accept_cr);

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      alert_hr   <= 1'b0;
      is_cable   <= 1'b0;
      timeout    <= 1'b0;
      byte_count <= 8'h00;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      alert_hr   <= alert_hr_nxt;
      is_cable   <= is_cable_nxt;
      timeout    <= timeout_nxt;
      byte_count <= byte_count_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    is_cable_nxt   = is_cable;
    timeout_nxt    = timeout;
    byte_count_nxt = byte_count;
    // W1C clear loses to a set landing in the same cycle
    alert_hr_nxt   = alert_hr & ~bus.ALERT_clear[3];
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt    = RESET_LAYER;
          is_cable_nxt = accept_cr;
          timeout_nxt  = 1'b0;
        end
      end
      RESET_LAYER: begin
        state_nxt      = INDICATE;
        alert_hr_nxt   = 1'b1;
        byte_count_nxt = 8'h00;
      end
      INDICATE: begin
        state_nxt = WAIT_PE;
        timer_nxt = '0;
      end
      WAIT_PE: begin
        if (bus.PE_hard_reset_done) begin
          state_nxt = COMPLETE;
        end else if (timer == TMR_LAST) begin
          state_nxt   = COMPLETE;
          timeout_nxt = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      COMPLETE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign bus.ALERT                = {12'h000, alert_hr, 3'b000};
  assign bus.prl_layer_reset      = (state == RESET_LAYER);
  assign bus.rx_buffer_flush      = (state == RESET_LAYER);
  assign bus.RECEIVE_DETECT_clear = (state == RESET_LAYER);
  assign bus.PE_hard_reset_ind    = (state == INDICATE);
  assign bus.hr_done              = (state == COMPLETE);
  assign bus.hr_busy              = (state != IDLE);
  assign bus.rx_is_cable          = is_cable;
  assign bus.hr_timeout           = timeout;
  assign bus.RECEIVE_BYTE_COUNT   = byte_count;

`ifdef HR_RX_EVENT_COUNT_EN
  logic [7:0] evt_cnt;
  always_ff @(posedge CLK) begin
    if (!reset)                        evt_cnt <= 8'h00;
    else if (accept && evt_cnt != 8'hFF) evt_cnt <= evt_cnt + 8'h01;
  end
  assign bus.hr_event_count = evt_cnt;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.RECEIVE_DETECT[7], bus.RECEIVE_DETECT[4:0],
                         bus.ALERT_clear[15:4], bus.ALERT_clear[2:0]};

endmodule

// File: tb/tb_prl_hard_reset_rx.sv
// Directed bench for prl_hard_reset_rx, built with an 8-cycle PE timeout.
module tb_prl_hard_reset_rx;
  logic CLK = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  prl_hard_reset_rx_if bus ();

  prl_hard_reset_rx #(.TIMEOUT_CYCLES(8), .TIMER_W(10)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_alert"}, bus.ALERT, 16'h0000);
    chk({tag, "_busy"},  {15'd0, bus.hr_busy}, 16'h0000);
    chk({tag, "_pulses"}, {10'd0, bus.prl_layer_reset, bus.rx_buffer_flush, bus.RECEIVE_DETECT_clear,
                           bus.PE_hard_reset_ind, bus.hr_done, bus.hr_timeout}, 16'h0000);
    chk({tag, "_cable"}, {15'd0, bus.rx_is_cable}, 16'h0000);
    chk({tag, "_bytecnt"}, {8'd0, bus.RECEIVE_BYTE_COUNT}, 16'h0000);
  endtask

  initial begin
    reset = 1'b0;
    bus.PHY_rx_hard_reset  = 1'b0;
    bus.PHY_rx_cable_reset = 1'b0;
    bus.RECEIVE_DETECT     = 8'h00;
    bus.ALERT_clear        = 16'h0000;
    bus.PE_hard_reset_done = 1'b0;
    tick(2);
    chk_idle_zero("reset");
    reset = 1'b1;
    tick(1);

    // T1: enabled Hard Reset, PE done 5 cycles after the indication
    bus.RECEIVE_DETECT    = 8'h20;
    bus.PHY_rx_hard_reset = 1'b1;
    tick(1);
    bus.PHY_rx_hard_reset = 1'b0;
    chk("t1_layer_reset", {15'd0, bus.prl_layer_reset}, 16'h0001);
    chk("t1_flush", {15'd0, bus.rx_buffer_flush}, 16'h0001);
    chk("t1_rd_clear", {15'd0, bus.RECEIVE_DETECT_clear}, 16'h0001);
    chk("t1_ind_early", {15'd0, bus.PE_hard_reset_ind}, 16'h0000);
    chk("t1_alert_early", bus.ALERT, 16'h0000);
    tick(1);
    chk("t1_ind", {15'd0, bus.PE_hard_reset_ind}, 16'h0001);
    chk("t1_layer_reset_off", {15'd0, bus.prl_layer_reset}, 16'h0000);
    chk("t1_alert", bus.ALERT, 16'h0008);
    chk("t1_cable", {15'd0, bus.rx_is_cable}, 16'h0000);
    tick(5);
    chk("t1_wait_busy", {15'd0, bus.hr_busy}, 16'h0001);
    chk("t1_wait_nodone", {15'd0, bus.hr_done}, 16'h0000);
    bus.PE_hard_reset_done = 1'b1;
    tick(1);
    bus.PE_hard_reset_done = 1'b0;
    chk("t1_done", {15'd0, bus.hr_done}, 16'h0001);
    chk("t1_timeout", {15'd0, bus.hr_timeout}, 16'h0000);
    tick(1);
    chk("t1_idle", {14'd0, bus.hr_busy, bus.hr_done}, 16'h0000);

    // T2: only Cable enabled, both pulse together; a pulse while busy is dropped
    bus.RECEIVE_DETECT     = 8'h40;
    bus.PHY_rx_hard_reset  = 1'b1;
    bus.PHY_rx_cable_reset = 1'b1;
    tick(1);
    bus.PHY_rx_hard_reset  = 1'b0;
    bus.PHY_rx_cable_reset = 1'b0;
    chk("t2_layer_reset", {15'd0, bus.prl_layer_reset}, 16'h0001);
    tick(1);
    chk("t2_cable", {15'd0, bus.rx_is_cable}, 16'h0001);
    tick(1);
    bus.PE_hard_reset_done = 1'b1;
    bus.PHY_rx_cable_reset = 1'b1;
    tick(1);
    bus.PE_hard_reset_done = 1'b0;
    bus.PHY_rx_cable_reset = 1'b0;
    chk("t2_done", {15'd0, bus.hr_done}, 16'h0001);
    tick(2);
    chk("t2_dropped", {15'd0, bus.hr_busy}, 16'h0000);
`ifdef HR_RX_EVENT_COUNT_EN
    chk("t2_count", {8'd0, bus.hr_event_count}, 16'h0002);
`endif

    // T3: both types disabled; stray PE done in IDLE is ignored
    bus.RECEIVE_DETECT     = 8'h00;
    bus.PHY_rx_hard_reset  = 1'b1;
    bus.PHY_rx_cable_reset = 1'b1;
    bus.PE_hard_reset_done = 1'b1;
    tick(1);
    bus.PHY_rx_hard_reset  = 1'b0;
    bus.PHY_rx_cable_reset = 1'b0;
    bus.PE_hard_reset_done = 1'b0;
    chk("t3_busy", {15'd0, bus.hr_busy}, 16'h0000);
    chk("t3_layer_reset", {15'd0, bus.prl_layer_reset}, 16'h0000);
    tick(1);
    chk("t3_busy2", {14'd0, bus.hr_busy, bus.hr_done}, 16'h0000);
    chk("t3_alert", bus.ALERT, 16'h0008);
    chk("t3_cable_held", {15'd0, bus.rx_is_cable}, 16'h0001);

    // T5: plain clear, then clear colliding with a new set
    bus.ALERT_clear = 16'h0008;
    tick(1);
    bus.ALERT_clear = 16'h0000;
    chk("t5_plain_clear", bus.ALERT, 16'h0000);
    bus.RECEIVE_DETECT    = 8'h20;
    bus.PHY_rx_hard_reset = 1'b1;
    tick(1);
    bus.PHY_rx_hard_reset = 1'b0;
    bus.ALERT_clear       = 16'h0008;
    tick(1);
    bus.ALERT_clear = 16'h0000;
    chk("t5_set_wins", bus.ALERT, 16'h0008);

    // T4a: no PE done -> forced completion after 8 WAIT_PE cycles
    tick(1);
    tick(7);
    chk("t4_still_wait", {14'd0, bus.hr_busy, bus.hr_done}, 16'h0002);
    chk("t4_no_timeout_yet", {15'd0, bus.hr_timeout}, 16'h0000);
    tick(1);
    chk("t4_forced_done", {15'd0, bus.hr_done}, 16'h0001);
    chk("t4_timeout", {15'd0, bus.hr_timeout}, 16'h0001);
    tick(1);
    chk("t4_timeout_sticky", {14'd0, bus.hr_timeout, bus.hr_busy}, 16'h0002);

    // T4b: done exactly on the 8th WAIT_PE cycle -> no timeout
    bus.PHY_rx_hard_reset = 1'b1;
    tick(1);
    bus.PHY_rx_hard_reset = 1'b0;
    chk("t4b_timeout_cleared", {15'd0, bus.hr_timeout}, 16'h0000);
    tick(2);
    tick(7);
    bus.PE_hard_reset_done = 1'b1;
    tick(1);
    bus.PE_hard_reset_done = 1'b0;
    chk("t4b_done", {15'd0, bus.hr_done}, 16'h0001);
    chk("t4b_no_timeout", {15'd0, bus.hr_timeout}, 16'h0000);
    tick(1);

    // T6: reset in WAIT_PE aborts the event, then a fresh event runs
    bus.RECEIVE_DETECT     = 8'h40;
    bus.PHY_rx_cable_reset = 1'b1;
    tick(1);
    bus.PHY_rx_cable_reset = 1'b0;
    tick(3);
    chk("t6_in_wait", {15'd0, bus.hr_busy}, 16'h0001);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    chk_idle_zero("t6_reset");
`ifdef HR_RX_EVENT_COUNT_EN
    chk("t6_count_reset", {8'd0, bus.hr_event_count}, 16'h0000);
`endif
    bus.RECEIVE_DETECT    = 8'h20;
    bus.PHY_rx_hard_reset = 1'b1;
    tick(1);
    bus.PHY_rx_hard_reset = 1'b0;
    chk("t6_layer_reset", {15'd0, bus.prl_layer_reset}, 16'h0001);
    tick(1);
    chk("t6_ind", {15'd0, bus.PE_hard_reset_ind}, 16'h0001);
    chk("t6_alert", bus.ALERT, 16'h0008);
    tick(1);
    bus.PE_hard_reset_done = 1'b1;
    tick(1);
    bus.PE_hard_reset_done = 1'b0;
    chk("t6_done", {15'd0, bus.hr_done}, 16'h0001);
`ifdef HR_RX_EVENT_COUNT_EN
    chk("t6_count", {8'd0, bus.hr_event_count}, 16'h0001);
`endif
    tick(1);
    chk("t6_idle", {14'd0, bus.hr_busy, bus.hr_done}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
